// File: rtl/gpio_reg_pkg.sv
// -----------------------------------------------------------------------------
// gpio_reg_pkg
// Shared definitions for the GPIO register port: register byte offsets,
// CTRL register bit positions, bus-master op-codes and master FSM state codes.
// Ports: none (package).
// -----------------------------------------------------------------------------
package gpio_reg_pkg;

    // Register byte offsets inside the GPIO register file
    localparam logic [31:0] REG_IN    = 32'h0000_0000;
    localparam logic [31:0] REG_OUT   = 32'h0000_0004;
    localparam logic [31:0] REG_OE    = 32'h0000_0008;
    localparam logic [31:0] REG_CTRL  = 32'h0000_000C;
    localparam logic [31:0] REG_IE    = 32'h0000_0010;
    localparam logic [31:0] REG_ISTAT = 32'h0000_0014;
    localparam logic [31:0] REG_ITYPE = 32'h0000_0018;
    localparam logic [31:0] REG_IPOL  = 32'h0000_001C;
    localparam logic [31:0] REG_DEB   = 32'h0000_0020;
    localparam logic [31:0] REG_NEC   = 32'h0000_0024;

    // CTRL register bit indices
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_LOCK_BIT   = 1;
    localparam int CTRL_DEB_EN_BIT = 2;

    // Command op-codes; 6 and 7 are reserved and rejected
    typedef enum logic [2:0] {
        OP_WR   = 3'd0,
        OP_RD   = 3'd1,
        OP_SET  = 3'd2,
        OP_CLR  = 3'd3,
        OP_TGL  = 3'd4,
        OP_POLL = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Master FSM state codes
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // A command is legal when the op-code is defined and the offset is a
    // word-aligned offset no larger than the highest register
    function automatic logic cmd_legal(input logic [2:0]  op,
                                       input logic [31:0] addr,
                                       input logic [31:0] max_addr);
        return (op <= 3'd5) && (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/gpio_reg_master_if.sv
// -----------------------------------------------------------------------------
// gpio_reg_master_if
// Bundles the host command/response channel and the GPIO register port.
//  cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data/cmd_mask : host command
//  rsp_valid/rsp_ready/rsp_data/rsp_err                  : response channel
//  busy                                                  : master not idle
//  gpio_we/gpio_addr/gpio_dat_o/gpio_dat_i               : register port
// Modports: master = host sequencer plus register file side,
//           slave  = gpio_reg_master.
// -----------------------------------------------------------------------------
interface gpio_reg_master_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [31:0]       cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              gpio_we;
    logic [31:0]       gpio_addr;
    logic [DATA_W-1:0] gpio_dat_o;
    logic [DATA_W-1:0] gpio_dat_i;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, gpio_dat_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, gpio_we, gpio_addr, gpio_dat_o
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, gpio_dat_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, gpio_we, gpio_addr, gpio_dat_o
    );
endinterface

// File: rtl/gpio_reg_master.sv
// -----------------------------------------------------------------------------
// gpio_reg_master
// Bus initiator for the GPIO register file. Executes one command at a time
// (write, read, set/clear/toggle bits, poll-until-match) as cycles on the
// register port and returns the result on a valid/ready response channel.
// Ports:
//  sysclk    : clock, rising edge
//  sysrst_n  : synchronous active-low reset
//  bus       : gpio_reg_master_if.slave (command, response, register port)
// All outputs are registers; they are loaded from the next-state decode so
// cmd_ready/busy/rsp_valid/gpio_we line up exactly with the state they mark.
// -----------------------------------------------------------------------------
module gpio_reg_master
    import gpio_reg_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] MAX_ADDR = 32'h0000_0024,
    parameter int          POLL_MAX = 16,
    parameter int          POLL_GAP = 4
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    gpio_reg_master_if.slave    bus
);

    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam int GCNT_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] mask_r;
    logic [PCNT_W-1:0] pcnt_r;
    logic [GCNT_W-1:0] gcnt_r;

    logic              cmd_ready_r;
    logic              busy_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_err_r;
    logic              gpio_we_r;
    logic [31:0]       gpio_addr_r;
    logic [DATA_W-1:0] gpio_dat_o_r;

    logic              accept_s;
    logic              legal_s;
    logic              match_s;
    logic              last_poll_s;
    logic              gap_done_s;

    // Read-modify-write data path: the three bit operations share one mux
    function automatic logic [DATA_W-1:0] apply_op(input logic [2:0]        op,
                                                   input logic [DATA_W-1:0] rd,
                                                   input logic [DATA_W-1:0] pat);
        logic [DATA_W-1:0] res;
        case (op)
            OP_SET:  res = rd | pat;
            OP_CLR:  res = rd & ~pat;
            OP_TGL:  res = rd ^ pat;
            default: res = rd;
        endcase
        return res;
    endfunction

    // Next-state decode and per-state condition flags
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = bus.cmd_valid & cmd_ready_r;
        legal_s     = cmd_legal(bus.cmd_op, bus.cmd_addr, MAX_ADDR);
        match_s     = ((bus.gpio_dat_i ^ data_r) & mask_r) == {DATA_W{1'b0}};
        last_poll_s = (pcnt_r == PCNT_W'(1));
        gap_done_s  = (gcnt_r == GCNT_W'(1));
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!legal_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (bus.cmd_op == OP_WR) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                case (op_r)
                    OP_SET, OP_CLR, OP_TGL: state_nxt_s = ST_WR;
                    OP_POLL: begin
                        if (match_s || last_poll_s) begin
                            state_nxt_s = ST_RESP;
                        end else if (POLL_GAP == 0) begin
                            state_nxt_s = ST_RD;
                        end else begin
                            state_nxt_s = ST_GAP;
                        end
                    end
                    default: state_nxt_s = ST_RESP;
                endcase
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_GAP: begin
                if (gap_done_s) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, command latches, counters and registered outputs
    always_ff @(posedge sysclk) begin
        if (!sysrst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= 3'd0;
            data_r       <= {DATA_W{1'b0}};
            mask_r       <= {DATA_W{1'b0}};
            pcnt_r       <= {PCNT_W{1'b0}};
            gcnt_r       <= {GCNT_W{1'b0}};
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp_err_r    <= 1'b0;
            gpio_we_r    <= 1'b0;
            gpio_addr_r  <= 32'h0000_0000;
            gpio_dat_o_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            gpio_we_r   <= (state_nxt_s == ST_WR);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= bus.cmd_op;
                        data_r <= bus.cmd_data;
                        mask_r <= bus.cmd_mask;
                        pcnt_r <= PCNT_W'(POLL_MAX);
                        if (legal_s) begin
                            // The register port only moves for legal commands
                            gpio_addr_r <= bus.cmd_addr;
                            if (bus.cmd_op == OP_WR) begin
                                gpio_dat_o_r <= bus.cmd_data;
                            end else begin
                                gpio_dat_o_r <= gpio_dat_o_r;
                            end
                        end else begin
                            rsp_data_r <= {DATA_W{1'b0}};
                            rsp_err_r  <= 1'b1;
                        end
                    end else begin
                        op_r <= op_r;
                    end
                end
                ST_RD: begin
                    case (op_r)
                        OP_SET, OP_CLR, OP_TGL: begin
                            gpio_dat_o_r <= apply_op(op_r, bus.gpio_dat_i, data_r);
                        end
                        OP_POLL: begin
                            rsp_data_r <= bus.gpio_dat_i;
                            if (match_s) begin
                                rsp_err_r <= 1'b0;
                            end else if (last_poll_s) begin
                                rsp_err_r <= 1'b1;
                            end else begin
                                pcnt_r <= pcnt_r - PCNT_W'(1);
                                gcnt_r <= GCNT_W'(POLL_GAP);
                            end
                        end
                        default: begin
                            rsp_data_r <= bus.gpio_dat_i;
                            rsp_err_r  <= 1'b0;
                        end
                    endcase
                end
                ST_WR: begin
                    // Write-type commands report the value actually written
                    rsp_data_r <= gpio_dat_o_r;
                    rsp_err_r  <= 1'b0;
                end
                ST_GAP: begin
                    if (!gap_done_s) begin
                        gcnt_r <= gcnt_r - GCNT_W'(1);
                    end else begin
                        gcnt_r <= gcnt_r;
                    end
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.busy       = busy_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.gpio_we    = gpio_we_r;
    assign bus.gpio_addr  = gpio_addr_r;
    assign bus.gpio_dat_o = gpio_dat_o_r;

endmodule
